load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 32, number of word locations in the attached data memory.
REQ-002 SHALL have parameter WORDSIZE, default 32, bits per memory location; only 32 is supported.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  core presents a memory request.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width/sign code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  core accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended per funct3; 0 for stores.
REQ-014 SHALL have port rsp_err  output  1  request rejected: misaligned, or funct3 illegal for the operation.
REQ-015 SHALL have memory-side ports memRead, memWrite (output 1), address (output 5, word index), writeData (output 32), readData (input 32, valid the cycle after memRead is sampled).

Function
REQ-016 SHALL implement states IDLE, RD, WR, RSP.
REQ-017 SHALL capture req_* on the edge where req_valid && req_ready.
REQ-018 SHALL drive address = req_addr[6:2]; req_addr[31:7] is ignored.
REQ-019 Load: IDLE -> RD (memRead=1, one cycle) -> RSP; rsp_rdata is built from readData in the RSP entry cycle, so rsp_valid rises 2 cycles after acceptance.
REQ-020 Word store: IDLE -> WR (memWrite=1, writeData=req_wdata, one cycle) -> RSP.
REQ-021 Byte/half store: IDLE -> RD -> WR -> RSP; writeData = readData with only the addressed byte lanes replaced (read-modify-write).
REQ-022 Byte lane = addr[1:0]; half lane = addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
REQ-023 Illegal funct3 (011, 110, 111; 100/101 on store) SHALL go IDLE -> RSP with rsp_err=1 and no memRead/memWrite.
REQ-024 RSP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_valid && rsp_ready, then return to IDLE; no new request is accepted in the same cycle.
REQ-025 memRead and memWrite SHALL never both be 1 and each SHALL assert for exactly one cycle per access.

Reset
REQ-026 On reset_n=0, SHALL immediately force state=IDLE, memRead=0, memWrite=0, address=0, writeData=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 An in-flight transaction SHALL be dropped with no response; req_ready=1 from the first edge after reset_n rises.

Configuration
REQ-028 With MISALIGN_TRAP_EN defined, halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 SHALL take IDLE -> RSP with rsp_err=1 and no memory strobe.
REQ-029 Without MISALIGN_TRAP_EN, misaligned low address bits SHALL be forced to alignment (half: addr[0]=0; word: addr[1:0]=0) and the access SHALL proceed normally.

Structure
REQ-030 A shared package lsu_pkg SHALL hold the funct3 constants, the state enum, and the width constants.
REQ-031 A combinational sub-module lsu_align SHALL perform lane extraction/extension for loads and lane merging for stores.

Verification
REQ-032 SW addr 0x0C data 0xDEADBEEF, then LW addr 0x0C -> address=3, a single memWrite, rsp_rdata=0xDEADBEEF at 2 cycles after acceptance.
REQ-033 Word 3 = 0xDEADBEEF, SB addr 0x0D data 0x55 -> RD then WR, writeData=0xDEAD55EF.
REQ-034 Word 3 = 0xDEAD55EF, LB 0x0F -> 0xFFFFFFDE; LBU 0x0F -> 0x000000DE; LH 0x0E -> 0xFFFFDEAD.
REQ-035 LW addr 0x0E -> with MISALIGN_TRAP_EN: rsp_err=1, no strobes; without: reads word 3.
REQ-036 Hold rsp_ready=0 for 5 cycles in RSP -> rsp_valid/rsp_rdata stable, req_ready=0; assert reset_n=0 during RD -> memRead drops at once, no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and small decode helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BYTES = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RSP  = 2'b11
  } lsu_state_e;

  // Unsigned load widths have no store counterpart.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] force_align(input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] aligned;
    case (f3[1:0])
      2'b01:   aligned = {off[1], 1'b0};
      2'b10:   aligned = 2'b00;
      default: aligned = off;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane extraction/extension for loads and lane merging for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] mem_word,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged_word
);

  logic [XLEN-1:0]  shifted_s;
  logic [XLEN-1:0]  lane_data_s;
  logic [BYTES-1:0] byte_en_s;

  // Load path: move the addressed lane to bit 0, then extend.
  always_comb begin
    shifted_s = mem_word >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   load_data = {24'h00_0000, shifted_s[7:0]};
      F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   load_data = {16'h0000, shifted_s[15:0]};
      default: load_data = mem_word;
    endcase
  end

  // Store path: replicate the store data across lanes and keep only enabled bytes.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        byte_en_s   = 4'b0001 << offset;
        lane_data_s = {4{store_data[7:0]}};
      end
      2'b01: begin
        byte_en_s   = 4'b0011 << {offset[1], 1'b0};
        lane_data_s = {2{store_data[15:0]}};
      end
      default: begin
        byte_en_s   = 4'b1111;
        lane_data_s = store_data;
      end
    endcase
    for (int i = 0; i < BYTES; i++) begin
      merged_word[8*i +: 8] = byte_en_s[i] ? lane_data_s[8*i +: 8] : mem_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-addressed data memory; sub-word stores use read-modify-write.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of force-aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDRSIZE = 32,
  parameter int unsigned WORDSIZE = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [2:0]                  req_funct3,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [31:0]                 rsp_rdata,
  output logic                        rsp_err,
  output logic                        memRead,
  output logic                        memWrite,
  output logic [$clog2(ADDRSIZE)-1:0] address,
  output logic [WORDSIZE-1:0]         writeData,
  input  logic [WORDSIZE-1:0]         readData
);

  localparam int unsigned AW = $clog2(ADDRSIZE);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      offset_q, offset_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [AW-1:0]   address_q, address_d;
  logic            fill_q, fill_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [1:0]      req_off_s;
  logic            req_trap_s;
  logic [XLEN-1:0] load_data_s;
  logic [XLEN-1:0] merged_s;
  logic            unused_addr_s;

  assign unused_addr_s = ^req_addr[31:AW+2];

  // Misaligned low address bits either trap or are dropped.
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    req_off_s  = req_addr[1:0];
    req_trap_s = is_misaligned(req_funct3, req_addr[1:0]);
`else
    req_off_s  = force_align(req_funct3, req_addr[1:0]);
    req_trap_s = 1'b0;
`endif
  end

  lsu_align u_align (
    .funct3      (funct3_q),
    .offset      (offset_q),
    .mem_word    (readData),
    .store_data  (wdata_q),
    .load_data   (load_data_s),
    .merged_word (merged_s)
  );

  // Next-state and response logic.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    address_d   = address_q;
    fill_d      = fill_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          funct3_d  = req_funct3;
          offset_d  = req_off_s;
          wdata_d   = req_wdata;
          address_d = req_addr[AW+1:2];
          if (!f3_legal(req_we, req_funct3) || req_trap_s) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
            rsp_err_d   = 1'b1;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        // Stores reach here only for read-modify-write; loads finish one cycle into RSP.
        if (we_q) begin
          state_d = WR;
        end else begin
          state_d = RSP;
          fill_d  = 1'b1;
        end
      end
      WR: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
      end
      RSP: begin
        if (fill_q) begin
          fill_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data_s;
          rsp_err_d   = 1'b0;
        end else if (rsp_valid_q && rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        state_d     = IDLE;
        fill_d      = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Transaction and response registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      wdata_q     <= 32'h0000_0000;
      address_q   <= '0;
      fill_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      wdata_q     <= wdata_d;
      address_q   <= address_d;
      fill_q      <= fill_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Strobes decode straight from the state register so reset removes them immediately.
  always_comb begin
    memRead  = (state_q == RD);
    memWrite = (state_q == WR);
    if (state_q == WR) begin
      writeData = merged_s;
    end else begin
      writeData = '0;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign address   = address_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory and an independent reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        memRead, memWrite;
  logic [4:0]  address;
  logic [31:0] writeData, readData;
  logic        mem_init;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .memRead(memRead), .memWrite(memWrite), .address(address),
    .writeData(writeData), .readData(readData)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          nrd;
    int          nwr;
    int          lat;
    logic [4:0]  addr;
    logic [31:0] wd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] mem [32];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          rd_total = 0;
  int          wr_total = 0;
  int          both_total = 0;
  logic [4:0]  strobe_addr = 5'd0;
  logic [31:0] strobe_wd = 32'd0;

  function automatic logic [31:0] init_word(input int i);
    return 32'h3C00_0000 ^ (32'(i) * 32'h0101_0107);
  endfunction

  // Memory: read data appears the cycle after memRead is sampled.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      readData <= 32'd0;
    end else begin
      if (memWrite) mem[address] <= writeData;
      if (memRead) readData <= mem[address];
    end
  end

  always @(negedge clk) begin
    if (memRead) begin
      rd_total++;
      strobe_addr = address;
    end
    if (memWrite) begin
      wr_total++;
      strobe_addr = address;
      strobe_wd = writeData;
    end
    if (memRead && memWrite) both_total++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_off(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return a[1:0];
`else
    if (f3 == 3'b010) return 2'd0;
    else if (f3[1:0] == 2'b01) return {a[1], 1'b0};
    else return a[1:0];
`endif
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    bad = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
`ifdef MISALIGN_TRAP_EN
    bad = bad || ((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a[1:0] != 2'b00));
`endif
    return bad;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    int          o;
    o = int'(off);
    b = w[8*o +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] old,
                                            input logic [31:0] wd, input logic [1:0] off);
    logic [31:0] r;
    int          o;
    r = old;
    o = int'(off);
    case (f3[1:0])
      2'b00:   r[8*o +: 8] = wd[7:0];
      2'b01:   if (off[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    exp_t e;
    int   wait_cyc;
    int   lat;
    int   rd0;
    int   wr0;
    e.addr = a[6:2];
    e.err  = ref_err(we, f3, a);
    if (e.err) begin
      e.rdata = 32'd0; e.nrd = 0; e.nwr = 0; e.lat = 0; e.wd = 32'd0;
    end else if (we) begin
      e.wd = ref_store(f3, ref_mem[e.addr], wd, ref_off(f3, a));
      ref_mem[e.addr] = e.wd;
      e.rdata = 32'd0; e.nwr = 1;
      e.nrd = (f3 == 3'b010) ? 0 : 1;
      e.lat = (f3 == 3'b010) ? 1 : 2;
    end else begin
      e.rdata = ref_load(f3, ref_mem[e.addr], ref_off(f3, a));
      e.nrd = 1; e.nwr = 0; e.lat = 2; e.wd = 32'd0;
    end
    exp_q.push_back(e);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_eq("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    rd0 = rd_total;
    wr0 = wr_total;
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    e = exp_q.pop_front();
    check_eq("latency", 32'(lat), 32'(e.lat));
    check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
    check_eq("rsp_rdata", rsp_rdata, e.rdata);
    check_eq("req_ready_busy", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_rdata", rsp_rdata, e.rdata);
      check_eq("hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_eq("rsp_drop", 32'(rsp_valid), 32'd0);
    check_eq("ready_back", 32'(req_ready), 32'd1);
    check_eq("n_memread", 32'(rd_total - rd0), 32'(e.nrd));
    check_eq("n_memwrite", 32'(wr_total - wr0), 32'(e.nwr));
    if (e.nrd + e.nwr > 0) check_eq("mem_address", 32'(strobe_addr), 32'(e.addr));
    if (e.nwr > 0) check_eq("write_data", strobe_wd, e.wd);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010; f3_tab[3] = 3'b100;
    f3_tab[4] = 3'b101; f3_tab[5] = 3'b011; f3_tab[6] = 3'b010; f3_tab[7] = 3'b001;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);

    reset_n = 1'b0; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_memread", 32'(memRead), 32'd0);
    check_eq("rst_memwrite", 32'(memWrite), 32'd0);
    check_eq("rst_address", 32'(address), 32'd0);
    check_eq("rst_writedata", writeData, 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; mem_init = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_reset", 32'(req_ready), 32'd1);

    do_req(1'b1, 3'b010, 32'h0000_000C, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 3'b010, 32'h0000_000C, 32'd0, 0);
    do_req(1'b1, 3'b000, 32'h0000_000D, 32'h0000_0055, 0);
    do_req(1'b0, 3'b000, 32'h0000_000F, 32'd0, 0);
    do_req(1'b0, 3'b100, 32'h0000_000F, 32'd0, 0);
    do_req(1'b0, 3'b001, 32'h0000_000E, 32'd0, 0);
    do_req(1'b0, 3'b101, 32'h0000_000E, 32'd0, 0);
    do_req(1'b0, 3'b000, 32'h0000_000C, 32'd0, 0);
    do_req(1'b0, 3'b001, 32'h0000_000C, 32'd0, 0);
    do_req(1'b1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 0);
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'd0, 0);
    do_req(1'b0, 3'b011, 32'h0000_0010, 32'd0, 0);
    do_req(1'b1, 3'b100, 32'h0000_0010, 32'h0000_00AA, 0);
    do_req(1'b0, 3'b111, 32'h0000_0010, 32'd0, 0);
    do_req(1'b0, 3'b010, 32'h0000_000E, 32'd0, 0);
    do_req(1'b1, 3'b001, 32'h0000_0015, 32'h0000_7766, 0);
    do_req(1'b0, 3'b010, 32'h0000_0014, 32'd0, 0);
    do_req(1'b0, 3'b010, 32'hFFFF_FF8C, 32'd0, 0);
    do_req(1'b0, 3'b000, 32'h0000_000F, 32'd0, 5);

    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)], $urandom,
             $urandom, int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a load's memory read.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("rd_strobe_before_reset", 32'(memRead), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rd_drop_async", 32'(memRead), 32'd0);
    check_eq("addr_async_clear", 32'(address), 32'd0);
    check_eq("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
      check_eq("idle_after_reset", 32'(req_ready), 32'd1);
    end
    do_req(1'b0, 3'b010, 32'h0000_000C, 32'd0, 0);

    check_eq("strobes_exclusive", 32'(both_total), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
